// File: rtl/mmio_pkg.sv
// ============================================================================
// Module : mmio_pkg
// Brief  : Register map addresses and output FSM state type for mmio_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

  localparam logic [7:0] MMIO_LED     = 8'h00;
  localparam logic [7:0] MMIO_IN_VLD  = 8'h04;
  localparam logic [7:0] MMIO_IN_DAT  = 8'h08;
  localparam logic [7:0] MMIO_OUT_RDY = 8'h0C;
  localparam logic [7:0] MMIO_SEG     = 8'h10;
  localparam logic [7:0] MMIO_CNT     = 8'h14;
  localparam logic [7:0] MMIO_STAT    = 8'h18;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } seg_state_t;

endpackage

`default_nettype wire

// File: rtl/mmio_if.sv
// ============================================================================
// Module : mmio_if
// Brief  : CPU IO bus bundle (address, write data, strobes, read data).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmio_if;

  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;

  modport master (
    output io_addr,
    output io_dout,
    output io_we,
    output io_rd,
    input  io_din
  );

  modport slave (
    input  io_addr,
    input  io_dout,
    input  io_we,
    input  io_rd,
    output io_din
  );

endinterface

`default_nettype wire

// File: rtl/seg_hold_timer.sv
// ============================================================================
// Module : seg_hold_timer
// Brief  : IDLE/HOLD FSM keeping busy high for HOLD_CYCLES cycles per start.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_hold_timer
  import mmio_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic start,
  output logic      busy
);

  localparam int              CW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   C_LOAD = CW'(HOLD_CYCLES - 1);

  seg_state_t    r_state;
  seg_state_t    w_state_nxt;
  logic [CW-1:0] r_hold;
  logic [CW-1:0] w_hold_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Loading HOLD_CYCLES-1 and leaving at zero gives exactly HOLD_CYCLES busy cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = C_LOAD;
        end
      end
      S_HOLD: begin
        if (r_hold == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_nxt = r_hold - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  assign busy = (r_state == S_HOLD);

endmodule

`default_nettype wire

// File: rtl/mmio_ctrl.sv
// ============================================================================
// Module : mmio_ctrl
// Brief  : CPU memory-mapped IO controller (LEDs, switches, 7-seg, status).
//          Optional cycle counter at 0x14 enabled by MMIO_CYCLE_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000,
  parameter int SW_W        = 16
) (
  input  wire logic            clk,
  input  wire logic            rstn,
  mmio_if.slave                io,
  input  wire logic [SW_W-1:0] sw,
  input  wire logic            sw_pulse,
  output logic      [SW_W-1:0] led,
  output logic      [31:0]     seg_data,
  output logic                 seg_vld,
  output logic                 ovf
);

  logic [SW_W-1:0] r_led;
  logic [SW_W-1:0] r_in_dat;
  logic            r_in_vld;
  logic [31:0]     r_seg_data;
  logic            r_ovf;
  logic [31:0]     w_cnt;
  logic [7:0]      w_addr;
  logic            w_led_wr;
  logic            w_seg_wr;
  logic            w_stat_wr;
  logic            w_indat_rd;
  logic            w_busy;
  logic            w_seg_accept;
  logic            w_in_drop;
  logic            w_seg_reject;

  assign w_addr       = io.io_addr & 8'hFC;
  assign w_led_wr     = io.io_we && (w_addr == MMIO_LED);
  assign w_seg_wr     = io.io_we && (w_addr == MMIO_SEG);
  assign w_stat_wr    = io.io_we && (w_addr == MMIO_STAT);
  assign w_indat_rd   = io.io_rd && (w_addr == MMIO_IN_DAT);
  assign w_seg_accept = w_seg_wr && !w_busy;
  assign w_seg_reject = w_seg_wr && w_busy;
  // A pulse coinciding with an IN_DAT read refills the slot instead of dropping.
  assign w_in_drop    = sw_pulse && r_in_vld && !w_indat_rd;

  seg_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_seg_hold_timer (
    .clk   (clk),
    .rstn  (rstn),
    .start (w_seg_accept),
    .busy  (w_busy)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_led      <= '0;
      r_in_dat   <= '0;
      r_in_vld   <= 1'b0;
      r_seg_data <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_led_wr) begin
        r_led <= io.io_dout[SW_W-1:0];
      end
      if (sw_pulse && (!r_in_vld || w_indat_rd)) begin
        r_in_dat <= sw;
        r_in_vld <= 1'b1;
      end else if (w_indat_rd) begin
        r_in_vld <= 1'b0;
      end
      if (w_seg_accept) begin
        r_seg_data <= io.io_dout;
      end
      if (w_in_drop || w_seg_reject) begin
        r_ovf <= 1'b1;
      end else if (w_stat_wr) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign w_cnt = r_cnt;
`else
  assign w_cnt = '0;
`endif

  always_comb begin
    io.io_din = '0;
    case (w_addr)
      MMIO_LED:     io.io_din = 32'(r_led);
      MMIO_IN_VLD:  io.io_din = {31'd0, r_in_vld};
      MMIO_IN_DAT:  io.io_din = 32'(r_in_dat);
      MMIO_OUT_RDY: io.io_din = {31'd0, !w_busy};
      MMIO_SEG:     io.io_din = r_seg_data;
      MMIO_CNT:     io.io_din = w_cnt;
      MMIO_STAT:    io.io_din = {31'd0, r_ovf};
      default:      io.io_din = '0;
    endcase
  end

  assign led      = r_led;
  assign seg_data = r_seg_data;
  assign seg_vld  = w_busy;
  assign ovf      = r_ovf;

endmodule

`default_nettype wire
